// File: rtl/mem_arbiter.sv
// Arbitrates the single backing memory port between I-cache fills and D-cache
// fills/word writes. D wins by default; I is forced after STARVE_MAX D grants.
//   state | meaning
//   IDLE  | no transaction; arbitrate among unmasked requesters
//   I_RD  | I-cache line fill outstanding, waiting for mem_ready
//   D_RD  | D-cache line fill outstanding, waiting for mem_ready
//   D_WR  | D-cache word write outstanding, waiting for mem_done
module mem_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_ack,
  output logic [LINE_WORDS*WORD_SIZE-1:0] i_line,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [WORD_SIZE-1:0]            d_wdata,
  output logic                            d_ack,
  output logic [LINE_WORDS*WORD_SIZE-1:0] d_line,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_address,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
  input  logic                            mem_ready,
  input  logic                            mem_done,
  output logic [WORD_SIZE-1:0]            num_i_grants,
  output logic [WORD_SIZE-1:0]            num_d_grants
);

  localparam int LINE_W   = LINE_WORDS * WORD_SIZE;
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(LINE_WORDS - 1);
  localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

  state_t                state_q;
  logic                  i_ack_q, d_ack_q;
  logic [LINE_W-1:0]     i_line_q, d_line_q;
  logic                  mem_read_q, mem_write_q;
  logic [WORD_SIZE-1:0]  addr_q, wdata_q;
  logic [WORD_SIZE-1:0]  num_i_q, num_d_q;
  logic [STREAK_W-1:0]   streak_q;

  logic                  i_cand, d_cand, starve, grant_i, grant_d;
  logic [STREAK_W-1:0]   streak_d;

  // A requester whose ack is showing this cycle has not yet dropped its level.
  always_comb begin
    i_cand   = i_req & ~i_ack_q;
    d_cand   = d_req & ~d_ack_q;
    starve   = (streak_q == STREAK_MAX);
    grant_i  = (state_q == IDLE) & i_cand & (~d_cand | starve);
    grant_d  = (state_q == IDLE) & d_cand & ~grant_i;
    streak_d = '0;
    if (i_cand) begin
      streak_d = starve ? streak_q : streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_line_q    <= '0;
      d_line_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      num_i_q     <= '0;
      num_d_q     <= '0;
      streak_q    <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q    <= I_RD;
            mem_read_q <= 1'b1;
            addr_q     <= i_addr & ALIGN_MASK;
            num_i_q    <= num_i_q + WORD_SIZE'(1);
            streak_q   <= '0;
          end else if (grant_d) begin
            wdata_q  <= d_wdata;
            num_d_q  <= num_d_q + WORD_SIZE'(1);
            streak_q <= streak_d;
            if (d_we) begin
              state_q     <= D_WR;
              mem_write_q <= 1'b1;
              addr_q      <= d_addr;
            end else begin
              state_q    <= D_RD;
              mem_read_q <= 1'b1;
              addr_q     <= d_addr & ALIGN_MASK;
            end
          end
        end
        I_RD: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            i_line_q   <= mem_rdata;
            i_ack_q    <= 1'b1;
          end
        end
        D_RD: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            mem_read_q <= 1'b0;
            d_line_q   <= mem_rdata;
            d_ack_q    <= 1'b1;
          end
        end
        D_WR: begin
          if (mem_done) begin
            state_q     <= IDLE;
            mem_write_q <= 1'b0;
            d_ack_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign i_line       = i_line_q;
  assign d_line       = d_line_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign num_i_grants = num_i_q;
  assign num_d_grants = num_d_q;

endmodule
